// File: rtl/round_sequencer.sv
// One play session: spawns a target per round in lanes 0..3, times the response window,
// and judges each round as a hit or a miss, keeping the session's score and miss counts.
module round_sequencer #(
  parameter int unsigned GAP_CYCLES     = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned STEP_CYCLES    = 2_000_000,
  parameter int unsigned ROUNDS         = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  // hit_valid is a single-cycle strobe with no ready: a move is consumed on the cycle it is
  // presented, judged only in SHOW, and silently dropped in every other state.
  input  logic       hit_valid,
  input  logic [1:0] hit_dir,
  output logic       target_valid,
  output logic [1:0] target_pos,
  output logic [3:0] score,
  output logic [3:0] miss,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       round_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SHOW = 2'd2,
    S_DONE = 2'd3
  } fsm_t;

  localparam logic [2:0]  PLAYING  = 3'b010;
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [4:0]  ROUNDS_W = 5'(ROUNDS);

  fsm_t        fsm, fsm_n;
  logic [31:0] timer, timer_n;
  logic [15:0] lfsr, lfsr_n;
  logic [1:0]  prev_pos, prev_pos_n;
  logic        target_valid_n;
  logic [1:0]  target_pos_n;
  logic [3:0]  score_n, miss_n;
  logic        hit_pulse_n, miss_pulse_n, round_done_n;

  logic        playing;
  logic [31:0] window;
  logic [1:0]  spawn_pos;
  logic [4:0]  total_n;

  assign playing   = (state == PLAYING);
  assign window    = 32'(TIMEOUT_CYCLES) - 32'(score) * 32'(STEP_CYCLES);
  // Never show the same lane twice in a row.
  assign spawn_pos = (lfsr[1:0] == prev_pos) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
  assign total_n   = {1'b0, score_n} + {1'b0, miss_n};
  assign dbg_state = fsm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= S_IDLE;
      timer        <= '0;
      lfsr         <= LFSR_SEED;
      prev_pos     <= '0;
      target_valid <= 1'b0;
      target_pos   <= '0;
      score        <= '0;
      miss         <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      fsm          <= fsm_n;
      timer        <= timer_n;
      lfsr         <= lfsr_n;
      prev_pos     <= prev_pos_n;
      target_valid <= target_valid_n;
      target_pos   <= target_pos_n;
      score        <= score_n;
      miss         <= miss_n;
      hit_pulse    <= hit_pulse_n;
      miss_pulse   <= miss_pulse_n;
      round_done   <= round_done_n;
    end
  end

  always_comb begin
    fsm_n          = fsm;
    timer_n        = timer;
    lfsr_n         = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    prev_pos_n     = prev_pos;
    target_valid_n = target_valid;
    target_pos_n   = target_pos;
    score_n        = score;
    miss_n         = miss;
    hit_pulse_n    = 1'b0;
    miss_pulse_n   = 1'b0;
    round_done_n   = round_done;

    case (fsm)
      S_IDLE: begin
        if (playing) begin
          score_n = '0;
          miss_n  = '0;
          timer_n = '0;
          fsm_n   = S_GAP;
        end
      end
      S_GAP: begin
        target_valid_n = 1'b0;
        if (!playing) begin
          timer_n = '0;
          fsm_n   = S_IDLE;
        end else if (timer == GAP_LAST) begin
          target_pos_n   = spawn_pos;
          prev_pos_n     = spawn_pos;
          target_valid_n = 1'b1;
          timer_n        = '0;
          fsm_n          = S_SHOW;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      S_SHOW: begin
        if (!playing) begin
          target_valid_n = 1'b0;
          timer_n        = '0;
          fsm_n          = S_IDLE;
        end else if (hit_valid || (timer == window - 32'd1)) begin
          // A move on the timeout cycle takes precedence over the timeout.
          if (hit_valid && (hit_dir == target_pos)) begin
            score_n     = score + 4'd1;
            hit_pulse_n = 1'b1;
          end else begin
            miss_n       = miss + 4'd1;
            miss_pulse_n = 1'b1;
          end
          target_valid_n = 1'b0;
          timer_n        = '0;
          if (total_n == ROUNDS_W) begin
            round_done_n = 1'b1;
            fsm_n        = S_DONE;
          end else begin
            fsm_n = S_GAP;
          end
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      S_DONE: begin
        target_valid_n = 1'b0;
        if (!playing) begin
          round_done_n = 1'b0;
          fsm_n        = S_IDLE;
        end
      end
      default: fsm_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: scripted and randomized rounds checked against a
// round-level model of score, miss, window length and lane choice.
module tb_round_sequencer;

  localparam int GAP    = 4;
  localparam int TO     = 20;
  localparam int STEP   = 1;
  localparam int ROUNDS = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       hit_valid;
  logic [1:0] hit_dir;
  logic       target_valid;
  logic [1:0] target_pos;
  logic [3:0] score, miss;
  logic       hit_pulse, miss_pulse, round_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int passes = 0;
  int exp_score, exp_miss, collisions;
  logic [1:0] exp_prev;

  round_sequencer #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .STEP_CYCLES(STEP),
    .ROUNDS(ROUNDS), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .hit_valid(hit_valid), .hit_dir(hit_dir),
    .target_valid(target_valid), .target_pos(target_pos), .score(score), .miss(miss),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .round_done(round_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference random source: the specified 16-bit Fibonacci LFSR (taps 16,14,13,11).
  // m_lfsr_prev holds the value the design sampled at the most recent edge.
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Waits for the next target; exp_cycles counts negedges from the call.
  task automatic wait_spawn(input int exp_cycles, input bit noise);
    int n = 0;
    bit seen = 0;
    bit bad = 0;
    logic [1:0] cand;
    while (!seen && n < 60) begin
      if (noise) begin
        hit_valid = 1'($urandom_range(0, 1));
        hit_dir   = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      n++;
      if (hit_pulse || miss_pulse) bad = 1;
      if (target_valid) seen = 1;
    end
    hit_valid = 1'b0;
    checks++;
    if (n !== exp_cycles) $display("FAIL spawn_latency: got %0d cycles, expected %0d", n, exp_cycles);
    else passes++;
    checks++;
    if (bad) $display("FAIL gap_pulse: pulse seen while no target shown");
    else passes++;
    cand = m_lfsr_prev[1:0];
    if (cand == exp_prev) begin
      cand = cand + 2'd1;
      collisions++;
    end
    checks++;
    if (target_pos !== cand || target_pos === exp_prev)
      $display("FAIL spawn_lane: got %0d, expected %0d (previous %0d)", target_pos, cand, exp_prev);
    else passes++;
    checks++;
    if (score !== 4'(exp_score) || miss !== 4'(exp_miss))
      $display("FAIL gap_counters: got score %0d miss %0d, expected %0d %0d", score, miss, exp_score, exp_miss);
    else passes++;
    exp_prev = cand;
  endtask

  // The judge tasks start on the negedge where the new target was first seen.
  task automatic judge_hit(input int d);
    repeat (d) @(negedge clk);
    hit_valid = 1'b1;
    hit_dir   = exp_prev;
    @(negedge clk);
    hit_valid = 1'b0;
    exp_score++;
    checks++;
    if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 4'(exp_score) || miss !== 4'(exp_miss)
        || target_valid !== 1'b0 || round_done !== (exp_score + exp_miss == ROUNDS))
      $display("FAIL hit_judge: hp %0b mp %0b score %0d miss %0d tv %0b done %0b, expected score %0d miss %0d",
               hit_pulse, miss_pulse, score, miss, target_valid, round_done, exp_score, exp_miss);
    else passes++;
  endtask

  task automatic judge_wrong(input int d);
    repeat (d) @(negedge clk);
    hit_valid = 1'b1;
    hit_dir   = exp_prev ^ 2'($urandom_range(1, 3));
    @(negedge clk);
    hit_valid = 1'b0;
    exp_miss++;
    checks++;
    if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 4'(exp_score) || miss !== 4'(exp_miss)
        || target_valid !== 1'b0 || round_done !== (exp_score + exp_miss == ROUNDS))
      $display("FAIL wrong_lane: hp %0b mp %0b score %0d miss %0d tv %0b done %0b, expected score %0d miss %0d",
               hit_pulse, miss_pulse, score, miss, target_valid, round_done, exp_score, exp_miss);
    else passes++;
  endtask

  task automatic judge_timeout();
    int w = TO - exp_score * STEP;
    int n = 0;
    bit found = 0;
    bit early_hit = 0;
    while (!found && n < w + 5) begin
      @(negedge clk);
      n++;
      if (miss_pulse) found = 1;
      if (hit_pulse) early_hit = 1;
    end
    exp_miss++;
    checks++;
    if (n !== w || early_hit) $display("FAIL timeout_window: miss after %0d cycles, expected %0d", n, w);
    else passes++;
    checks++;
    if (score !== 4'(exp_score) || miss !== 4'(exp_miss) || target_valid !== 1'b0
        || round_done !== (exp_score + exp_miss == ROUNDS))
      $display("FAIL timeout_counters: score %0d miss %0d tv %0b done %0b, expected %0d %0d",
               score, miss, target_valid, round_done, exp_score, exp_miss);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 3'b000; hit_valid = 1'b0; hit_dir = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({target_valid, target_pos, score, miss, hit_pulse, miss_pulse, round_done} !== 15'd0)
      $display("FAIL reset_outputs: got %b, expected all zero",
               {target_valid, target_pos, score, miss, hit_pulse, miss_pulse, round_done});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    exp_score = 0; exp_miss = 0; exp_prev = 2'd0;
  endtask

  task automatic test_start();
    state = 3'b010;
    wait_spawn(5, 0);
  endtask

  // 7 hits and 3 misses in a fixed mix of outcomes.
  task automatic test_scripted_session();
    judge_timeout();
    wait_spawn(4, 1); judge_hit(3);
    wait_spawn(4, 1); judge_timeout();
    wait_spawn(4, 1); judge_wrong(2);
    wait_spawn(4, 1); judge_hit(TO - exp_score * STEP - 1);
    for (int r = 0; r < 5; r++) begin
      wait_spawn(4, 1);
      judge_hit($urandom_range(0, TO - exp_score * STEP - 1));
    end
  endtask

  task automatic test_done();
    bit bad = 0;
    checks++;
    if (round_done !== 1'b1 || score !== 4'd7 || miss !== 4'd3)
      $display("FAIL done_totals: done %0b score %0d miss %0d, expected 1 7 3", round_done, score, miss);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      hit_valid = 1'($urandom_range(0, 1));
      hit_dir   = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (hit_pulse || miss_pulse || target_valid || !round_done || score !== 4'd7 || miss !== 4'd3) bad = 1;
    end
    hit_valid = 1'b0;
    checks++;
    if (bad) $display("FAIL done_frozen: activity after session end");
    else passes++;
    state = 3'b001;
    @(negedge clk);
    checks++;
    if (round_done !== 1'b0 || score !== 4'd7 || miss !== 4'd3)
      $display("FAIL done_exit: done %0b score %0d miss %0d, expected 0 7 3", round_done, score, miss);
    else passes++;
  endtask

  task automatic test_abort();
    bit bad = 0;
    state = 3'b010;
    exp_score = 0; exp_miss = 0;
    wait_spawn(5, 0);
    judge_hit($urandom_range(0, TO - 1));
    wait_spawn(4, 1);
    judge_wrong($urandom_range(0, TO - 2));
    wait_spawn(4, 0);
    repeat (2) @(negedge clk);
    state = 3'b110;
    @(negedge clk);
    checks++;
    if (target_valid !== 1'b0 || score !== 4'd1 || miss !== 4'd1 || hit_pulse || miss_pulse)
      $display("FAIL abort_show: tv %0b score %0d miss %0d, expected 0 1 1", target_valid, score, miss);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      hit_valid = 1'($urandom_range(0, 1));
      hit_dir   = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (target_valid || hit_pulse || miss_pulse || score !== 4'd1 || miss !== 4'd1) bad = 1;
    end
    hit_valid = 1'b0;
    checks++;
    if (bad) $display("FAIL abort_idle: activity after abort");
    else passes++;
    // Restart, then abort during the gap before the first target.
    state = 3'b010;
    repeat (3) @(negedge clk);
    checks++;
    if (score !== 4'd0 || miss !== 4'd0) $display("FAIL restart_clear: score %0d miss %0d, expected 0 0", score, miss);
    else passes++;
    state = 3'b101;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (target_valid) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL abort_gap: target shown after abort in gap");
    else passes++;
  endtask

  task automatic test_random_session();
    int w;
    state = 3'b010;
    exp_score = 0; exp_miss = 0;
    wait_spawn(5, 0);
    for (int r = 0; r < ROUNDS; r++) begin
      if (r > 0) wait_spawn(4, 1);
      w = TO - exp_score * STEP;
      case ($urandom_range(0, 2))
        0:       judge_hit($urandom_range(0, w - 1));
        1:       judge_wrong($urandom_range(0, w - 1));
        default: judge_timeout();
      endcase
    end
    checks++;
    if (round_done !== 1'b1 || score !== 4'(exp_score) || miss !== 4'(exp_miss))
      $display("FAIL random_totals: done %0b score %0d miss %0d, expected 1 %0d %0d",
               round_done, score, miss, exp_score, exp_miss);
    else passes++;
  endtask

  task automatic test_async_reset();
    state = 3'b001;
    @(negedge clk);
    state = 3'b010;
    exp_score = 0; exp_miss = 0;
    wait_spawn(5, 0);
    judge_hit(1);
    wait_spawn(4, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({target_valid, target_pos, score, miss, hit_pulse, miss_pulse, round_done} !== 15'd0)
      $display("FAIL async_reset: got %b, expected all zero",
               {target_valid, target_pos, score, miss, hit_pulse, miss_pulse, round_done});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    exp_score = 0; exp_miss = 0; exp_prev = 2'd0;
    wait_spawn(5, 0);
    judge_hit(0);
  endtask

  initial begin
    collisions = 0;
    test_reset();
    test_start();
    test_scripted_session();
    test_done();
    test_abort();
    test_random_session();
    test_async_reset();
    $display("lane collisions resolved: %0d, final fsm code %0d", collisions, dbg_state);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
